// File: rtl/gerador_ticks_if.sv
// gerador_ticks_if: divisor-write channel into the tick generator.
//   cfg_valid  master->slave  write request
//   cfg_ch     master->slave  target channel index (CH_W bits)
//   cfg_div    master->slave  new divisor (WIDTH bits)
//   cfg_ready  slave->master  write can be accepted this cycle
interface gerador_ticks_if #(
    parameter int WIDTH = 26,
    parameter int CH_W  = 2
);
    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/gerador_ticks.sv
// gerador_ticks: synchronous tick generator. N_CH channels each emit a
// one-cycle enable pulse every D enabled cycles (D programmable at runtime),
// a 50% square wave toggling on each tick, and a scan counter advanced by
// the tick of channel SCAN_CH.
//
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous active-high reset
//   enable  global run; low freezes counters and squares, forces tick low
//   cfg     divisor write channel (gerador_ticks_if.slave)
//   tick    per-channel one-cycle pulse
//   square  per-channel square output
//   scan    wrap-around display scan counter
//
// Optional feature: define TICK_RELOAD_IMMEDIATE_EN to apply a pending
// divisor on the edge after acceptance (cnt and tick cleared, no terminal
// tick). Without it, a pending divisor is applied at the target channel's
// terminal count so the output phase never glitches.
module gerador_ticks #(
    parameter int WIDTH       = 26,
    parameter int N_CH        = 3,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int SCAN_BITS   = 2,
    parameter int SCAN_CH     = 2,
    parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    gerador_ticks_if.slave       cfg,
    output logic [N_CH-1:0]      tick,
    output logic [N_CH-1:0]      square,
    output logic [SCAN_BITS-1:0] scan
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

    logic [WIDTH-1:0]     div_r [N_CH];
    logic [WIDTH-1:0]     cnt_r [N_CH];
    logic [N_CH-1:0]      tick_r;
    logic [N_CH-1:0]      square_r;
    logic [SCAN_BITS-1:0] scan_r;
    logic                 pend_r;
    logic [CH_W-1:0]      pend_ch_r;
    logic [WIDTH-1:0]     pend_div_r;

    logic [N_CH-1:0]      term_s;
    logic [N_CH-1:0]      apply_s;
    logic                 accept_s;
    logic                 ch_ok_s;

    // Terminal-count and pending-apply decode per channel, plus write acceptance.
    always_comb begin
        term_s  = {N_CH{1'b0}};
        apply_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            term_s[i] = enable && (div_r[i] != ZERO_C) && (cnt_r[i] == (div_r[i] - ONE_C));
`ifdef TICK_RELOAD_IMMEDIATE_EN
            apply_s[i] = pend_r && (pend_ch_r == CH_W'(i));
`else
            // A disabled channel (D=0) never reaches terminal count, so it
            // takes the new divisor on the very next edge instead.
            apply_s[i] = pend_r && (pend_ch_r == CH_W'(i)) &&
                         ((div_r[i] == ZERO_C) || term_s[i]);
`endif
        end
        accept_s = cfg.cfg_valid && !pend_r;
        ch_ok_s  = (32'(cfg.cfg_ch) < 32'(N_CH));
    end

    // Channel counters, outputs, scan counter and the single pending slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                div_r[i] <= WIDTH'(DEFAULT_DIV);
                cnt_r[i] <= ZERO_C;
            end
            tick_r     <= {N_CH{1'b0}};
            square_r   <= {N_CH{1'b0}};
            scan_r     <= {SCAN_BITS{1'b0}};
            pend_r     <= 1'b0;
            pend_ch_r  <= {CH_W{1'b0}};
            pend_div_r <= ZERO_C;
        end else begin
            // Apply and accept are mutually exclusive: accept needs pend low.
            if (|apply_s) begin
                pend_r <= 1'b0;
            end else if (accept_s && ch_ok_s) begin
                pend_r     <= 1'b1;
                pend_ch_r  <= cfg.cfg_ch;
                pend_div_r <= cfg.cfg_div;
            end else begin
                pend_r <= pend_r;
            end

            for (int i = 0; i < N_CH; i++) begin
`ifdef TICK_RELOAD_IMMEDIATE_EN
                if (apply_s[i]) begin
                    div_r[i]  <= pend_div_r;
                    cnt_r[i]  <= ZERO_C;
                    tick_r[i] <= 1'b0;
                end else
`endif
                if (div_r[i] == ZERO_C) begin
                    cnt_r[i]  <= ZERO_C;
                    tick_r[i] <= 1'b0;
                    if (apply_s[i]) begin
                        div_r[i] <= pend_div_r;
                    end
                end else if (!enable) begin
                    tick_r[i] <= 1'b0;
                end else if (term_s[i]) begin
                    // Terminal tick is still emitted on an apply edge.
                    cnt_r[i]    <= ZERO_C;
                    tick_r[i]   <= 1'b1;
                    square_r[i] <= ~square_r[i];
                    if (apply_s[i]) begin
                        div_r[i] <= pend_div_r;
                    end
                end else begin
                    cnt_r[i]  <= cnt_r[i] + ONE_C;
                    tick_r[i] <= 1'b0;
                end
            end

            if (tick_r[SCAN_CH]) begin
                scan_r <= scan_r + SCAN_BITS'(1'b1);
            end else begin
                scan_r <= scan_r;
            end
        end
    end

    assign tick          = tick_r;
    assign square        = square_r;
    assign scan          = scan_r;
    assign cfg.cfg_ready = ~pend_r;

endmodule

// File: tb/tb_gerador_ticks.sv
// Scoreboard bench for gerador_ticks (WIDTH=8, N_CH=3, DEFAULT_DIV=4).
// Each phase restarts from reset; cycle k is the cycle after the k-th
// enabled edge following reset release. Expected tick events are pushed
// by the stimulus; the monitor pops one whenever any tick bit is high.
module tb_gerador_ticks;

    localparam int WIDTH     = 8;
    localparam int N_CH      = 3;
    localparam int DEF_DIV   = 4;
    localparam int SCAN_BITS = 2;
    localparam int SCAN_CH   = 2;
    localparam int CH_W      = 2;

    typedef struct {
        int         c;
        logic [2:0] t;
        logic [2:0] sq;
        logic [1:0] sc;
    } exp_t;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] tick;
    logic [2:0] square;
    logic [1:0] scan;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];

    gerador_ticks_if #(.WIDTH(WIDTH), .CH_W(CH_W)) cfg_if ();

    gerador_ticks #(
        .WIDTH(WIDTH), .N_CH(N_CH), .DEFAULT_DIV(DEF_DIV),
        .SCAN_BITS(SCAN_BITS), .SCAN_CH(SCAN_CH), .CH_W(CH_W)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .cfg    (cfg_if.slave),
        .tick   (tick),
        .square (square),
        .scan   (scan)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: every cycle with a tick must match the next expected event.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && tick !== 3'b000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick cyc=%0d got tick=%b square=%b scan=%0d, expected no tick",
                         cyc, tick, square, scan);
            end else begin
                e = exp_q.pop_front();
                if (e.c != cyc || tick !== e.t || square !== e.sq || scan !== e.sc) begin
                    errors++;
                    $display("FAIL tick_event got cyc=%0d tick=%b square=%b scan=%0d, expected cyc=%0d tick=%b square=%b scan=%0d",
                             cyc, tick, square, scan, e.c, e.t, e.sq, e.sc);
                end
            end
        end
    end

    task automatic expect_tick(input int c, input logic [2:0] t, input logic [2:0] sq, input logic [1:0] sc);
        exp_t e;
        e.c = c; e.t = t; e.sq = sq; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, expv);
        end
    endtask

    // Advance to just after the negedge of cycle n.
    task automatic goto(input int n);
        int g = 0;
        while (cyc != n && g <= 200) begin
            @(negedge clock);
            g++;
        end
        if (g > 200) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout got cyc=%0d expected %0d", cyc, n);
        end
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] ch, input logic [7:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_div   = d;
    endtask

    // Close a phase (all expected ticks seen), reset, check reset state, release.
    task automatic do_reset(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_ticks got %0d pending expected 0", name, exp_q.size());
        end
        exp_q.delete();
        reset            = 1'b1;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        @(posedge clock); #1;
        check({name, "_rst_tick"},   32'(tick),             32'h0);
        check({name, "_rst_square"}, 32'(square),           32'h0);
        check({name, "_rst_scan"},   32'(scan),             32'h0);
        check({name, "_rst_ready"},  32'(cfg_if.cfg_ready), 32'h1);
        @(posedge clock); #1;
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 8'd0;

        // A: default divisor 4 on all channels.
        do_reset("init");
        expect_tick(4,  3'b111, 3'b111, 2'd0);
        expect_tick(8,  3'b111, 3'b000, 2'd1);
        expect_tick(12, 3'b111, 3'b111, 2'd2);
        goto(13);
        check("A_scan_wrap_3", 32'(scan), 32'd3);

        // B: ch1 D=2 written at cycle 1, applied at ch1's terminal count (cycle 4).
        do_reset("A");
        goto(1);  write_cfg(2'd1, 8'd2);
        goto(2);  cfg_if.cfg_valid = 1'b0;
        check("B_ready_low_c2", 32'(cfg_if.cfg_ready), 32'd0);
        goto(3);  check("B_ready_low_c3", 32'(cfg_if.cfg_ready), 32'd0);
        expect_tick(4,  3'b111, 3'b111, 2'd0);
        expect_tick(6,  3'b010, 3'b101, 2'd1);
        expect_tick(8,  3'b111, 3'b010, 2'd1);
        expect_tick(10, 3'b010, 3'b000, 2'd2);
        expect_tick(12, 3'b111, 3'b111, 2'd2);
        goto(4);  check("B_ready_high_c4", 32'(cfg_if.cfg_ready), 32'd1);
        goto(13);

        // C: ch0 D=0 (disabled, square frozen), then D=3 applied on next edge.
        do_reset("B");
        goto(1);  write_cfg(2'd0, 8'd0);
        goto(2);  cfg_if.cfg_valid = 1'b0;
        expect_tick(4,  3'b111, 3'b111, 2'd0);
        expect_tick(8,  3'b110, 3'b001, 2'd1);
        expect_tick(12, 3'b110, 3'b111, 2'd2);
        expect_tick(14, 3'b001, 3'b110, 2'd3);
        expect_tick(16, 3'b110, 3'b000, 2'd3);
        expect_tick(17, 3'b001, 3'b001, 2'd0);
        goto(9);  check("C_ready_before_d3", 32'(cfg_if.cfg_ready), 32'd1);
        write_cfg(2'd0, 8'd3);
        goto(10); cfg_if.cfg_valid = 1'b0;
        check("C_ready_pend", 32'(cfg_if.cfg_ready), 32'd0);
        goto(11); check("C_ready_applied", 32'(cfg_if.cfg_ready), 32'd1);
        goto(18);

        // D: enable low for 5 edges mid-period delays the next tick by 5.
        do_reset("C");
        expect_tick(4,  3'b111, 3'b111, 2'd0);
        expect_tick(13, 3'b111, 3'b000, 2'd1);
        expect_tick(17, 3'b111, 3'b111, 2'd2);
        goto(5);  enable = 1'b0;
        goto(10); enable = 1'b1;
        check("D_scan_frozen", 32'(scan), 32'd1);
        goto(18);

        // E: out-of-range channel is accepted and discarded.
        do_reset("D");
        goto(1);  write_cfg(2'd3, 8'd2);
        goto(2);  cfg_if.cfg_valid = 1'b0;
        check("E_ready_c2", 32'(cfg_if.cfg_ready), 32'd1);
        goto(3);  check("E_ready_c3", 32'(cfg_if.cfg_ready), 32'd1);
        expect_tick(4, 3'b111, 3'b111, 2'd0);
        expect_tick(8, 3'b111, 3'b000, 2'd1);
        goto(9);

        // F: reset with a write pending and square high.
        do_reset("E");
        expect_tick(4, 3'b111, 3'b111, 2'd0);
        goto(5);  write_cfg(2'd0, 8'd2);
        goto(6);  cfg_if.cfg_valid = 1'b0;
        check("F_ready_pend", 32'(cfg_if.cfg_ready), 32'd0);
        check("F_square_high", 32'(square), 32'h7);
        do_reset("F_pre");
        // Divisors back to 4: ch0 must not tick at cycle 2.
        expect_tick(4, 3'b111, 3'b111, 2'd0);
        expect_tick(8, 3'b111, 3'b000, 2'd1);
        goto(9);

        // G: ch2 D=1 ticks every cycle and drives scan every cycle.
        do_reset("F_post");
        goto(1);  write_cfg(2'd2, 8'd1);
        goto(2);  cfg_if.cfg_valid = 1'b0;
        expect_tick(4, 3'b111, 3'b111, 2'd0);
        expect_tick(5, 3'b100, 3'b011, 2'd1);
        expect_tick(6, 3'b100, 3'b111, 2'd2);
        expect_tick(7, 3'b100, 3'b011, 2'd3);
        expect_tick(8, 3'b111, 3'b100, 2'd0);
        goto(8);

        do_reset("G");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
